// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the RV32I memory stage: control word,
//               load/store funct3 encodings, memory FSM states and opcodes.
//               Ports: none (package).
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef logic [6:0] rv32i_opcode;

    localparam rv32i_opcode OP_LOAD  = 7'b0000011;
    localparam rv32i_opcode OP_STORE = 7'b0100011;
    localparam rv32i_opcode OP_REG   = 7'b0110011;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic        mem_read;
        logic        mem_write;
        logic        load_regfile;
        logic [4:0]  rd;
    } rv32i_control_word;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Data-memory bus between the MEM stage (master) and memory
//               (slave).
//               data_read/data_write : request strobes (master -> slave)
//               data_addr/data_mbe/data_wdata : word address, byte enables,
//                                               lane-shifted store data
//               data_rdata/data_resp : read data and one-cycle completion
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_addr;
    logic [3:0]  data_mbe;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_resp;

    modport master (
        output data_read,
        output data_write,
        output data_addr,
        output data_mbe,
        output data_wdata,
        input  data_rdata,
        input  data_resp
    );

    modport slave (
        input  data_read,
        input  data_write,
        input  data_addr,
        input  data_mbe,
        input  data_wdata,
        output data_rdata,
        output data_resp
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Combinational access-size logic for the MEM stage.
//               funct3    : access size / signedness
//               addr_lo   : low two address bits
//               rs2       : store source data
//               rdata     : memory read word
//               aligned   : access is naturally aligned
//               mbe       : byte enables for the access
//               wdata     : store data replicated onto every lane
//               load_data : extracted and extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Loads and stores share the funct3[1:0] size code, so one decode
    // serves both directions.
    always_comb begin
        aligned = 1'b1;
        mbe     = 4'b0000;
        wdata   = 32'h0;
        case (funct3[1:0])
            2'b00: begin
                aligned = 1'b1;
                mbe     = 4'b0001 << addr_lo;
                wdata   = {4{rs2[7:0]}};
            end
            2'b01: begin
                aligned = ~addr_lo[0];
                mbe     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata   = {2{rs2[15:0]}};
            end
            default: begin
                aligned = (addr_lo == 2'b00);
                mbe     = 4'b1111;
                wdata   = rs2;
            end
        endcase
    end

    always_comb begin
        w_byte    = rdata[{addr_lo, 3'b000} +: 8];
        w_half    = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_data = rdata;
        case (load_funct3_t'(funct3))
            LB:      load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     load_data = {24'h0, w_byte};
            LH:      load_data = {{16{w_half[15]}}, w_half};
            LHU:     load_data = {16'h0, w_half};
            default: load_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32I MEM pipeline stage. Issues data-memory requests, stalls
//               the front of the pipeline until the memory responds, and
//               holds the MEM/WB pipeline register and performance counters.
//               clk, rst (sync, active-low)
//               ex_mem_valid/ctrl/alu_out/rs2 : EX/MEM register contents
//               dmem                          : data-memory bus (master)
//               mem_stall                     : freeze upstream stages
//               mem_wb_*                      : MEM/WB register outputs
//               stall_cycles, mem_ops         : performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import rv32i_types::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_mem_valid,
    input  rv32i_control_word    ex_mem_ctrl,
    input  logic [31:0]          ex_mem_alu_out,
    input  logic [31:0]          ex_mem_rs2,
    mem_stage_if.master          dmem,
    output logic                 mem_stall,
    output logic                 mem_wb_valid,
    output rv32i_control_word    mem_wb_ctrl,
    output logic [31:0]          mem_wb_alu_out,
    output logic [31:0]          mem_wb_rdata,
    output logic                 mem_wb_misaligned,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] mem_ops
);

    mem_state_t state_q, state_d;

    // Copy of the outstanding request, so the bus stays stable in WAIT.
    logic        req_read_q,  req_read_d;
    logic        req_write_q, req_write_d;
    logic [31:0] req_addr_q,  req_addr_d;
    logic [3:0]  req_mbe_q,   req_mbe_d;
    logic [31:0] req_wdata_q, req_wdata_d;

    logic              mem_wb_valid_q,      mem_wb_valid_d;
    rv32i_control_word mem_wb_ctrl_q,       mem_wb_ctrl_d;
    logic [31:0]       mem_wb_alu_out_q,    mem_wb_alu_out_d;
    logic [31:0]       mem_wb_rdata_q,      mem_wb_rdata_d;
    logic              mem_wb_misaligned_q, mem_wb_misaligned_d;

    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] mem_ops_q,      mem_ops_d;

    logic        w_aligned;
    logic [3:0]  w_mbe;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;
    logic        w_access;
    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_read;
    logic        w_write;
    logic [31:0] w_addr;
    logic [3:0]  w_bus_mbe;
    logic [31:0] w_bus_wdata;
    logic        w_req;
    logic        w_done;

    mem_align u_align (
        .funct3    (ex_mem_ctrl.funct3),
        .addr_lo   (ex_mem_alu_out[1:0]),
        .rs2       (ex_mem_rs2),
        .rdata     (dmem.data_rdata),
        .aligned   (w_aligned),
        .mbe       (w_mbe),
        .wdata     (w_wdata),
        .load_data (w_load_data)
    );

    assign w_access     = ex_mem_valid & (ex_mem_ctrl.mem_read | ex_mem_ctrl.mem_write);
    assign w_mem_op     = w_access & w_aligned;
    assign w_misaligned = w_access & ~w_aligned;

    // Bus request. Forced quiet during reset so an abandoned WAIT access
    // cannot leak a strobe. Read wins if a control word ever sets both.
    always_comb begin
        w_read      = 1'b0;
        w_write     = 1'b0;
        w_addr      = 32'h0;
        w_bus_mbe   = 4'b0000;
        w_bus_wdata = 32'h0;
        if (rst) begin
            if (state_q == WAIT) begin
                w_read      = req_read_q;
                w_write     = req_write_q;
                w_addr      = req_addr_q;
                w_bus_mbe   = req_mbe_q;
                w_bus_wdata = req_wdata_q;
            end else if (w_mem_op) begin
                w_read      = ex_mem_ctrl.mem_read;
                w_write     = ~ex_mem_ctrl.mem_read & ex_mem_ctrl.mem_write;
                w_addr      = {ex_mem_alu_out[31:2], 2'b00};
                w_bus_mbe   = w_mbe;
                w_bus_wdata = w_wdata;
            end
        end
    end

    assign w_req     = w_read | w_write;
    assign w_done    = w_req & dmem.data_resp;
    assign mem_stall = w_req & ~dmem.data_resp;

    assign dmem.data_read  = w_read;
    assign dmem.data_write = w_write;
    assign dmem.data_addr  = w_addr;
    assign dmem.data_mbe   = w_bus_mbe;
    assign dmem.data_wdata = w_bus_wdata;

    always_comb begin
        state_d     = state_q;
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_mbe_d   = req_mbe_q;
        req_wdata_d = req_wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d     = WAIT;
                    req_read_d  = w_read;
                    req_write_d = w_write;
                    req_addr_d  = w_addr;
                    req_mbe_d   = w_bus_mbe;
                    req_wdata_d = w_bus_wdata;
                end
            end
            WAIT: begin
                if (dmem.data_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MEM/WB takes a bubble while stalled so no consumer sees a load
    // before its data has arrived.
    always_comb begin
        mem_wb_valid_d      = 1'b0;
        mem_wb_ctrl_d       = '0;
        mem_wb_alu_out_d    = 32'h0;
        mem_wb_rdata_d      = 32'h0;
        mem_wb_misaligned_d = 1'b0;
        if (!mem_stall) begin
            mem_wb_valid_d                   = ex_mem_valid;
            mem_wb_ctrl_d                    = ex_mem_ctrl;
            mem_wb_ctrl_d.load_regfile       = ex_mem_ctrl.load_regfile & ~w_misaligned;
            mem_wb_alu_out_d                 = ex_mem_alu_out;
            mem_wb_misaligned_d              = w_misaligned;
            if (w_mem_op && ex_mem_ctrl.mem_read) begin
                mem_wb_rdata_d = w_load_data;
            end
        end
    end

    assign stall_cycles_d = stall_cycles_q + {{(CNT_WIDTH-1){1'b0}}, mem_stall};
    assign mem_ops_d      = mem_ops_q + {{(CNT_WIDTH-1){1'b0}}, w_done};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q             <= IDLE;
            req_read_q          <= 1'b0;
            req_write_q         <= 1'b0;
            req_addr_q          <= 32'h0;
            req_mbe_q           <= 4'b0000;
            req_wdata_q         <= 32'h0;
            mem_wb_valid_q      <= 1'b0;
            mem_wb_ctrl_q       <= '0;
            mem_wb_alu_out_q    <= 32'h0;
            mem_wb_rdata_q      <= 32'h0;
            mem_wb_misaligned_q <= 1'b0;
            stall_cycles_q      <= '0;
            mem_ops_q           <= '0;
        end else begin
            state_q             <= state_d;
            req_read_q          <= req_read_d;
            req_write_q         <= req_write_d;
            req_addr_q          <= req_addr_d;
            req_mbe_q           <= req_mbe_d;
            req_wdata_q         <= req_wdata_d;
            mem_wb_valid_q      <= mem_wb_valid_d;
            mem_wb_ctrl_q       <= mem_wb_ctrl_d;
            mem_wb_alu_out_q    <= mem_wb_alu_out_d;
            mem_wb_rdata_q      <= mem_wb_rdata_d;
            mem_wb_misaligned_q <= mem_wb_misaligned_d;
            stall_cycles_q      <= stall_cycles_d;
            mem_ops_q           <= mem_ops_d;
        end
    end

    assign mem_wb_valid      = mem_wb_valid_q;
    assign mem_wb_ctrl       = mem_wb_ctrl_q;
    assign mem_wb_alu_out    = mem_wb_alu_out_q;
    assign mem_wb_rdata      = mem_wb_rdata_q;
    assign mem_wb_misaligned = mem_wb_misaligned_q;
    assign stall_cycles      = stall_cycles_q;
    assign mem_ops           = mem_ops_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: directed scenarios plus
//               randomized instructions against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import rv32i_types::*;

    localparam int CNT_W = 8;

    logic              clk;
    logic              rst;
    logic              ex_mem_valid;
    rv32i_control_word ex_mem_ctrl;
    logic [31:0]       ex_mem_alu_out;
    logic [31:0]       ex_mem_rs2;
    logic              mem_stall;
    logic              mem_wb_valid;
    rv32i_control_word mem_wb_ctrl;
    logic [31:0]       mem_wb_alu_out;
    logic [31:0]       mem_wb_rdata;
    logic              mem_wb_misaligned;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  mem_ops;

    mem_stage_if bus ();

    mem_stage #(.CNT_WIDTH(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_ctrl       (ex_mem_ctrl),
        .ex_mem_alu_out    (ex_mem_alu_out),
        .ex_mem_rs2        (ex_mem_rs2),
        .dmem              (bus.master),
        .mem_stall         (mem_stall),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_ctrl       (mem_wb_ctrl),
        .mem_wb_alu_out    (mem_wb_alu_out),
        .mem_wb_rdata      (mem_wb_rdata),
        .mem_wb_misaligned (mem_wb_misaligned),
        .stall_cycles      (stall_cycles),
        .mem_ops           (mem_ops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_stalls = 0;
    int exp_ops = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int     off;
        int     sz;
        longint v;
        longint span;
        off  = int'(addr % 4);
        sz   = size_of(f3);
        span = longint'(1) << (8 * sz);
        v    = (longint'(rdata) >> (8 * off)) % span;
        if (!f3[2] && sz < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_mbe(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = size_of(f3);
        return ((32'd1 << sz) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        int sz;
        sz = size_of(f3);
        if (sz == 1) return (rs2 % 256) * 32'h01010101;
        if (sz == 2) return (rs2 % 65536) * 32'h00010001;
        return rs2;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. Entered just after a rising edge;
    // returns just after the rising edge that commits the instruction.
    task automatic run_op(input int kind, input logic [2:0] f3, input logic valid,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int lat, input logic stray);
        bit access;
        bit aligned;
        bit memop;
        bit mis;
        int l;
        logic [4:0] rd;
        access  = valid && (kind != 0);
        aligned = (addr % size_of(f3)) == 0;
        memop   = access && aligned;
        mis     = access && !aligned;
        l       = memop ? lat : 0;
        rd      = 5'($urandom);

        ex_mem_valid             = valid;
        ex_mem_ctrl.opcode       = (kind == 1) ? OP_LOAD : (kind == 2) ? OP_STORE : OP_REG;
        ex_mem_ctrl.funct3       = f3;
        ex_mem_ctrl.mem_read     = (kind == 1);
        ex_mem_ctrl.mem_write    = (kind == 2);
        ex_mem_ctrl.load_regfile = (kind != 2);
        ex_mem_ctrl.rd           = rd;
        ex_mem_alu_out           = addr;
        ex_mem_rs2               = rs2;
        bus.data_rdata           = rdata;
        bus.data_resp            = memop ? (lat == 0) : stray;

        for (int k = 0; k <= l; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                check_eq("bubble_valid", 32'(mem_wb_valid), 32'd0);
                bus.data_resp = (k == l);
            end
            @(negedge clk);
            check_eq("data_read", 32'(bus.data_read), 32'(memop && kind == 1));
            check_eq("data_write", 32'(bus.data_write), 32'(memop && kind == 2));
            check_eq("mem_stall", 32'(mem_stall), 32'(memop && k < l));
            if (memop) check_eq("data_addr", bus.data_addr, addr & 32'hFFFF_FFFC);
            if (memop && kind == 2) begin
                check_eq("data_mbe", 32'(bus.data_mbe), ref_mbe(f3, addr));
                check_eq("data_wdata", bus.data_wdata, ref_wdata(f3, rs2));
            end
        end

        @(posedge clk); #1;
        bus.data_resp = 1'b0;
        if (memop) begin
            exp_stalls += l;
            exp_ops    += 1;
        end
        check_eq("wb_valid", 32'(mem_wb_valid), 32'(valid));
        if (valid) begin
            check_eq("wb_alu_out", mem_wb_alu_out, addr);
            check_eq("wb_misaligned", 32'(mem_wb_misaligned), 32'(mis));
            check_eq("wb_load_regfile", 32'(mem_wb_ctrl.load_regfile), 32'(kind != 2 && !mis));
            check_eq("wb_rd", 32'(mem_wb_ctrl.rd), 32'(rd));
            check_eq("wb_rdata", mem_wb_rdata,
                     (memop && kind == 1) ? ref_load(f3, addr, rdata) : 32'h0);
        end
        check_eq("stall_cycles", 32'(stall_cycles), 32'(exp_stalls % (1 << CNT_W)));
        check_eq("mem_ops", 32'(mem_ops), 32'(exp_ops % (1 << CNT_W)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  lf3 [5];
        logic [2:0]  f3;
        logic [31:0] addr;
        int          kind;
        lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        rst            = 1'b0;
        ex_mem_valid   = 1'b0;
        ex_mem_ctrl    = '0;
        ex_mem_alu_out = 32'h0;
        ex_mem_rs2     = 32'h0;
        bus.data_rdata = 32'h0;
        bus.data_resp  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_read", 32'(bus.data_read), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_wb_valid", 32'(mem_wb_valid), 32'd0);
        check_eq("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check_eq("rst_mem_ops", 32'(mem_ops), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed scenarios
        run_op(1, 3'b010, 1'b1, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0); // lw zero-wait
        run_op(1, 3'b000, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 1'b0); // lb
        run_op(1, 3'b100, 1'b1, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 1'b0); // lbu
        run_op(2, 3'b001, 1'b1, 32'h202, 32'h1234_ABCD, 32'h0, 2, 1'b0); // sh
        run_op(1, 3'b010, 1'b1, 32'h101, 32'h0, 32'h1111_1111, 2, 1'b1); // lw misaligned
        run_op(0, 3'b000, 1'b1, 32'hCAFE_0001, 32'h5, 32'h0, 0, 1'b1);   // ALU op

        // Reset landing in the second WAIT cycle
        ex_mem_valid             = 1'b1;
        ex_mem_ctrl.opcode       = OP_LOAD;
        ex_mem_ctrl.funct3       = 3'b000;
        ex_mem_ctrl.mem_read     = 1'b1;
        ex_mem_ctrl.mem_write    = 1'b0;
        ex_mem_ctrl.load_regfile = 1'b1;
        ex_mem_alu_out           = 32'h103;
        bus.data_resp            = 1'b0;
        @(negedge clk);
        check_eq("rw_issue_read", 32'(bus.data_read), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rw_wait1_read", 32'(bus.data_read), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rw_rst_read", 32'(bus.data_read), 32'd0);
        check_eq("rw_rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        rst           = 1'b1;
        ex_mem_valid  = 1'b0;
        bus.data_resp = 1'b1;
        exp_stalls    = 0;
        exp_ops       = 0;
        check_eq("rw_wb_valid", 32'(mem_wb_valid), 32'd0);
        check_eq("rw_stall_cycles", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        check_eq("rw_stray_read", 32'(bus.data_read), 32'd0);
        check_eq("rw_stray_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        bus.data_resp = 1'b0;
        check_eq("rw_mem_ops", 32'(mem_ops), 32'd0);
        run_op(1, 3'b010, 1'b1, 32'h400, 32'h0, 32'h0BAD_F00D, 1, 1'b0);

        // Randomized instruction stream; long enough to wrap 8-bit counters
        for (int i = 0; i < 500; i++) begin
            kind = $urandom_range(0, 2);
            f3   = (kind == 1) ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size_of(f3) - 1);
            run_op(kind, f3, 1'($urandom_range(0, 9) != 0), addr, $urandom, $urandom,
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32, giving the width of the performance counters.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 ex_mem_valid  in  1  EX/MEM register holds a live instruction.
REQ-005 ex_mem_ctrl  in  rv32i_control_word  control word of the EX/MEM instruction; uses opcode, funct3, mem_read, mem_write, load_regfile, rd.
REQ-006 ex_mem_alu_out  in  32  effective address or ALU result.
REQ-007 ex_mem_rs2  in  32  forwarded store data.
REQ-008 data_read / data_write  out  1 each  data-memory request strobes.
REQ-009 data_addr  out  32  word-aligned address: {alu_out[31:2], 2'b00}.
REQ-010 data_mbe  out  4  byte enables; data_wdata  out  32  lane-shifted store data.
REQ-011 data_rdata  in  32  read data; data_resp  in  1  one-cycle completion pulse.
REQ-012 mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM this cycle.
REQ-013 mem_wb_valid, mem_wb_ctrl, mem_wb_alu_out (32), mem_wb_rdata (32), mem_wb_misaligned (1)  out  registered MEM/WB pipeline register.
REQ-014 stall_cycles, mem_ops  out  CNT_WIDTH  performance counters.

Function
REQ-015 A memory op is ex_mem_valid & (mem_read | mem_write) & aligned; aligned: lw/sw need addr[1:0]==0, lh/lhu/sh need addr[0]==0, byte ops always aligned.
REQ-016 FSM states IDLE and WAIT; reset state IDLE.
REQ-017 IDLE: a memory op drives its request combinationally in the same cycle; data_resp that cycle completes it and the FSM stays in IDLE; otherwise the FSM moves to WAIT.
REQ-018 WAIT: hold data_read/data_write, data_addr, data_mbe and data_wdata stable; on data_resp go to IDLE.
REQ-019 Never assert data_read and data_write together; requests are zero when no memory op is present.
REQ-020 mem_stall = request asserted & ~data_resp; a zero-wait memory causes no stall.
REQ-021 MEM/WB register loads when mem_stall==0; while stalled it loads valid=0 (bubble), so the forwarding unit never sees a half-finished load.
REQ-022 Load extract on data_rdata: lb/lbu byte at addr[1:0], lh/lhu half at addr[1], lw full word; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-023 Store: sb mbe=4'b0001<<addr[1:0], wdata=rs2[7:0] replicated ×4; sh mbe=4'b0011<<{addr[1],1'b0}, wdata=rs2[15:0] replicated ×2; sw mbe=4'b1111, wdata=rs2.
REQ-024 Misaligned access: no request, no stall; mem_wb_misaligned=1 and mem_wb_ctrl.load_regfile forced to 0.
REQ-025 Non-memory instructions pass through in one cycle with alu_out unchanged and mem_wb_rdata=0.
REQ-026 stall_cycles increments in each cycle mem_stall=1; mem_ops increments on each data_resp; both wrap modulo 2^CNT_WIDTH.
REQ-027 data_resp while no request is asserted is ignored: no state change, no counter change.

Reset
REQ-028 While rst=0: state←IDLE, mem_wb_valid←0, mem_wb_ctrl/alu_out/rdata/misaligned←0, counters←0.
REQ-029 data_read, data_write and mem_stall SHALL be 0 in every cycle rst=0, including when reset lands mid-WAIT; the outstanding access is abandoned.

Structure
REQ-030 rv32i_types holds load_funct3_t, store_funct3_t, rv32i_control_word fields mem_read/mem_write/funct3, and mem_state_t {IDLE, WAIT}.
REQ-031 A combinational sub-module mem_align SHALL implement REQ-022/023 and the alignment check; mem_stage keeps the FSM, MEM/WB register and counters.

Verification
REQ-032 lw at 0x100, data_resp in the issue cycle -> no stall; next cycle mem_wb_valid=1, mem_wb_rdata=data_rdata.
REQ-033 lb at 0x103, rdata=0x80FFFFFF, resp after 3 cycles -> mem_stall=1 for 3 cycles, 3 bubbles, rdata=0xFFFFFF80; lbu -> 0x00000080.
REQ-034 sh at 0x202, rs2=0x1234ABCD -> data_addr=0x200, mbe=4'b1100, wdata=0xABCDABCD, held stable through WAIT.
REQ-035 lw at 0x101 -> no request, mem_wb_misaligned=1, load_regfile=0, stall_cycles unchanged.
REQ-036 rst=0 in WAIT cycle 2 -> data_read=0 in that cycle, then state IDLE; a stray data_resp afterwards is ignored and mem_ops stays 0.
